// File: rtl/raster_scan_scheduler.sv
// raster_scan_scheduler
// Accepts inclusive bounding boxes and streams every covered pixel coordinate in
// row-major order over a valid/ready channel. The bottom-right corner is clamped to
// the screen; boxes that end up empty are dropped with a one-cycle empty_skip pulse.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   bbox_valid/bbox_ready   bounding-box request handshake (ready only in IDLE)
//   bbox_min/bbox_max       inclusive corners, 10-bit x/y each
//   coord_valid/coord_ready coordinate stream handshake
//   coord, coord_metadata   current pixel and its .last flag (final pixel of a box)
//   busy                    high while a box is being emitted
//   empty_skip              one-cycle pulse after an accepted box that covers no pixels

package raster_scan_scheduler_pkg;
    localparam int unsigned COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_coordinate_t;

    typedef struct packed {
        logic last;
    } pixel_coordinate_metadata_t;
endpackage

module raster_scan_scheduler
    import raster_scan_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bbox_valid,
    output logic                       bbox_ready,
    input  pixel_coordinate_t          bbox_min,
    input  pixel_coordinate_t          bbox_max,
    output logic                       coord_valid,
    input  logic                       coord_ready,
    output pixel_coordinate_t          coord,
    output pixel_coordinate_metadata_t coord_metadata,
    output logic                       busy,
    output logic                       empty_skip
);

    localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(SCREEN_HEIGHT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e             state_q,      state_d;
    logic [COORD_W-1:0] min_x_q,      min_x_d;
    logic [COORD_W-1:0] max_x_q,      max_x_d;
    logic [COORD_W-1:0] max_y_q,      max_y_d;
    pixel_coordinate_t  coord_q,      coord_d;
    logic               last_q,       last_d;
    logic               empty_skip_q, empty_skip_d;

    logic [COORD_W-1:0] clamp_x;
    logic [COORD_W-1:0] clamp_y;
    logic               box_empty;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    // Clamp the incoming bottom-right corner to the screen and detect empty boxes
    always_comb begin
        clamp_x   = (bbox_max.x > X_LIMIT) ? X_LIMIT : bbox_max.x;
        clamp_y   = (bbox_max.y > Y_LIMIT) ? Y_LIMIT : bbox_max.y;
        box_empty = (bbox_min.x > clamp_x) || (bbox_min.y > clamp_y);
    end

    // Row-major successor of the current coordinate
    always_comb begin
        next_x = coord_q.x;
        next_y = coord_q.y;
        if (coord_q.x < max_x_q) begin
            next_x = coord_q.x + COORD_W'(1);
        end else begin
            next_x = min_x_q;
            next_y = coord_q.y + COORD_W'(1);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        max_y_d      = max_y_q;
        coord_d      = coord_q;
        last_d       = last_q;
        empty_skip_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bbox_valid) begin
                    if (box_empty) begin
                        empty_skip_d = 1'b1;
                    end else begin
                        min_x_d = bbox_min.x;
                        max_x_d = clamp_x;
                        max_y_d = clamp_y;
                        coord_d = bbox_min;
                        // last is precomputed so it is registered alongside coord
                        last_d  = (bbox_min.x == clamp_x) && (bbox_min.y == clamp_y);
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (coord_ready) begin
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        coord_d.x = next_x;
                        coord_d.y = next_y;
                        last_d    = (next_x == max_x_q) && (next_y == max_y_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            min_x_q      <= '0;
            max_x_q      <= '0;
            max_y_q      <= '0;
            coord_q      <= '0;
            last_q       <= 1'b0;
            empty_skip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            max_y_q      <= max_y_d;
            coord_q      <= coord_d;
            last_q       <= last_d;
            empty_skip_q <= empty_skip_d;
        end
    end

    assign bbox_ready          = (state_q == IDLE);
    assign coord_valid         = (state_q == EMIT);
    assign busy                = (state_q == EMIT);
    assign coord               = coord_q;
    assign coord_metadata.last = last_q;
    assign empty_skip          = empty_skip_q;

endmodule

// File: tb/tb_raster_scan_scheduler.sv
// Testbench for raster_scan_scheduler: table of directed boxes, stall and abort
// sequences, and random boxes checked against a queue-based pixel list model.
module tb_raster_scan_scheduler;
    import raster_scan_scheduler_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       bbox_valid;
    logic                       bbox_ready;
    pixel_coordinate_t          bbox_min;
    pixel_coordinate_t          bbox_max;
    logic                       coord_valid;
    logic                       coord_ready;
    pixel_coordinate_t          coord;
    pixel_coordinate_metadata_t coord_metadata;
    logic                       busy;
    logic                       empty_skip;

    int total = 0;
    int bad   = 0;

    raster_scan_scheduler #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
        .clk            (clk),
        .reset          (reset),
        .bbox_valid     (bbox_valid),
        .bbox_ready     (bbox_ready),
        .bbox_min       (bbox_min),
        .bbox_max       (bbox_max),
        .coord_valid    (coord_valid),
        .coord_ready    (coord_ready),
        .coord          (coord),
        .coord_metadata (coord_metadata),
        .busy           (busy),
        .empty_skip     (empty_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ax, ay, bx, by;
        int exp_n;
        int exp_lx, exp_ly;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, "_bbox_ready"}, 32'(bbox_ready), 32'd1);
        check({tag, "_coord_valid"}, 32'(coord_valid), 32'd0);
        check({tag, "_coord"}, 32'(coord), 32'd0);
        check({tag, "_last"}, 32'(coord_metadata.last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_empty_skip"}, 32'(empty_skip), 32'd0);
    endtask

    // Offer one box and consume its stream. mode: 0 always ready, 1 random ready,
    // 2 stalled 5 cycles then random. abort_after>0 resets after that many handshakes.
    // Outputs report what the DUT actually delivered.
    task automatic run_box(input int ax, input int ay, input int bx, input int by,
                           input int mode, input int abort_after,
                           output int n_out, output int last_x, output int last_y,
                           output int n_last);
        logic [19:0] exp_q[$];
        int cx, cy, hs, cyc;
        logic rdy;

        cx = (bx > 319) ? 319 : bx;
        cy = (by > 239) ? 239 : by;
        for (int y = ay; y <= cy; y++)
            for (int x = ax; x <= cx; x++)
                exp_q.push_back({10'(x), 10'(y)});

        n_out = 0; last_x = -1; last_y = -1; n_last = 0;

        @(negedge clk);
        check("ready_before_box", 32'(bbox_ready), 32'd1);
        bbox_valid = 1'b1;
        bbox_min   = '{x: 10'(ax), y: 10'(ay)};
        bbox_max   = '{x: 10'(bx), y: 10'(by)};
        coord_ready = 1'b0;
        @(negedge clk);
        bbox_valid = 1'b0;

        if (exp_q.size() == 0) begin
            check("empty_no_valid", 32'(coord_valid), 32'd0);
            check("empty_skip_pulse", 32'(empty_skip), 32'd1);
            check("empty_ready_stays", 32'(bbox_ready), 32'd1);
            @(negedge clk);
            check("empty_skip_drop", 32'(empty_skip), 32'd0);
            check("empty_no_valid2", 32'(coord_valid), 32'd0);
            return;
        end

        check("latency1_valid", 32'(coord_valid), 32'd1);
        check("emit_busy", 32'(busy), 32'd1);
        check("emit_not_ready", 32'(bbox_ready), 32'd0);
        check("emit_no_skip", 32'(empty_skip), 32'd0);

        hs = 0; cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 2000) begin
                check("stream_timeout", 32'd0, 32'd1);
                break;
            end
            check("stream_valid", 32'(coord_valid), 32'd1);
            check("stream_coord", 32'(coord), 32'(exp_q[0]));
            check("stream_last", 32'(coord_metadata.last), 32'(exp_q.size() == 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            coord_ready = rdy;
            // Requests offered during EMIT must be ignored
            bbox_valid = 1'($urandom_range(0, 1));
            bbox_min   = '{x: 10'($urandom_range(0, 1023)), y: 10'($urandom_range(0, 1023))};
            bbox_max   = '{x: 10'($urandom_range(0, 1023)), y: 10'($urandom_range(0, 1023))};
            if (rdy && coord_valid) begin
                n_out++;
                last_x = int'(coord.x);
                last_y = int'(coord.y);
                if (coord_metadata.last) n_last++;
                void'(exp_q.pop_front());
                hs++;
            end
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && hs == abort_after) begin
                // Reset collides with live handshakes; reset must win
                reset       = 1'b1;
                coord_ready = 1'b1;
                bbox_valid  = 1'b1;
                @(negedge clk);
                reset       = 1'b0;
                coord_ready = 1'b0;
                bbox_valid  = 1'b0;
                check_idle_reset_values("abort");
                return;
            end
        end
        bbox_valid  = 1'b0;
        coord_ready = 1'b0;
        check("done_valid_low", 32'(coord_valid), 32'd0);
        check("done_ready_high", 32'(bbox_ready), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int n, lx, ly, nl;

        vecs.push_back('{ax: 2,   ay: 3,   bx: 4,    by: 4,    exp_n: 6,   exp_lx: 4,   exp_ly: 4});
        vecs.push_back('{ax: 318, ay: 238, bx: 400,  by: 300,  exp_n: 4,   exp_lx: 319, exp_ly: 239});
        vecs.push_back('{ax: 5,   ay: 5,   bx: 4,    by: 9,    exp_n: 0,   exp_lx: -1,  exp_ly: -1});
        vecs.push_back('{ax: 7,   ay: 7,   bx: 7,    by: 7,    exp_n: 1,   exp_lx: 7,   exp_ly: 7});
        vecs.push_back('{ax: 0,   ay: 0,   bx: 319,  by: 0,    exp_n: 320, exp_lx: 319, exp_ly: 0});
        vecs.push_back('{ax: 310, ay: 239, bx: 1023, by: 1023, exp_n: 10,  exp_lx: 319, exp_ly: 239});
        vecs.push_back('{ax: 320, ay: 0,   bx: 400,  by: 5,    exp_n: 0,   exp_lx: -1,  exp_ly: -1});
        vecs.push_back('{ax: 0,   ay: 240, bx: 3,    by: 250,  exp_n: 0,   exp_lx: -1,  exp_ly: -1});

        reset = 1'b1; bbox_valid = 1'b0; coord_ready = 1'b0;
        bbox_min = '0; bbox_max = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_reset_values("reset");
        @(negedge clk);
        check_idle_reset_values("post_reset_idle");

        foreach (vecs[i]) begin
            run_box(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by, 0, 0, n, lx, ly, nl);
            check($sformatf("tbl%0d_count", i), 32'(n), 32'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0) begin
                check($sformatf("tbl%0d_last_x", i), 32'(lx), 32'(vecs[i].exp_lx));
                check($sformatf("tbl%0d_last_y", i), 32'(ly), 32'(vecs[i].exp_ly));
                check($sformatf("tbl%0d_last_flags", i), 32'(nl), 32'd1);
            end
        end

        // Stalled downstream, then random ready
        run_box(0, 0, 1, 0, 2, 0, n, lx, ly, nl);
        check("stall_count", 32'(n), 32'd2);
        check("stall_last_x", 32'(lx), 32'd1);

        // Abort mid-box, then a single-pixel box
        run_box(10, 10, 19, 19, 0, 3, n, lx, ly, nl);
        check("abort_count", 32'(n), 32'd3);
        check("abort_last_x", 32'(lx), 32'd12);
        run_box(0, 0, 0, 0, 0, 0, n, lx, ly, nl);
        check("after_abort_count", 32'(n), 32'd1);
        check("after_abort_last_flag", 32'(nl), 32'd1);

        // Random boxes with random backpressure
        for (int k = 0; k < 40; k++) begin
            int ax, ay, bx, by;
            ax = $urandom_range(0, 325);
            ay = $urandom_range(0, 245);
            bx = ax + $urandom_range(0, 6) - 1;
            by = ay + $urandom_range(0, 6) - 1;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            if (bx > 1023) bx = 1023;
            if (by > 1023) by = 1023;
            run_box(ax, ay, bx, by, 1, 0, n, lx, ly, nl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_scan_scheduler.md
RASTER_SCAN_SCHEDULER -- requirements
Module: raster_scan_scheduler

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320, horizontal pixel count; valid x range 0..SCREEN_WIDTH-1.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 240, vertical pixel count; valid y range 0..SCREEN_HEIGHT-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bbox_valid  input  1  bounding-box request valid.
REQ-006 SHALL have port bbox_ready  output  1  scheduler can accept a bounding box.
REQ-007 SHALL have port bbox_min  input  pixel_coordinate_t (20)  inclusive top-left corner.
REQ-008 SHALL have port bbox_max  input  pixel_coordinate_t (20)  inclusive bottom-right corner.
REQ-009 SHALL have port coord_valid  output  1  coordinate stream valid.
REQ-010 SHALL have port coord_ready  input  1  downstream rasterizer accepts coordinate.
REQ-011 SHALL have port coord  output  pixel_coordinate_t (20)  current pixel coordinate.
REQ-012 SHALL have port coord_metadata  output  pixel_coordinate_metadata_t (1)  .last set on final coordinate of a box.
REQ-013 SHALL have port busy  output  1  high while in EMIT.
REQ-014 SHALL have port empty_skip  output  1  one-cycle pulse when an accepted box produces no coordinates.

Function
REQ-015 SHALL implement two states: IDLE, EMIT.
REQ-016 SHALL drive bbox_ready = 1 exactly when in IDLE; a transfer occurs when bbox_valid && bbox_ready at a rising edge.
REQ-017 SHALL, on transfer, clamp: max_x' = min(bbox_max.x, SCREEN_WIDTH-1), max_y' = min(bbox_max.y, SCREEN_HEIGHT-1); min values unchanged; all compares unsigned 10-bit.
REQ-018 SHALL treat the box as empty if bbox_min.x > max_x' or bbox_min.y > max_y'.
REQ-019 SHALL, on an empty box, stay in IDLE, assert empty_skip for exactly the following cycle, and emit no coordinate.
REQ-020 SHALL, on a non-empty box, register min/clamped max, load coord = bbox_min, enter EMIT; coord_valid high the cycle after transfer (latency 1).
REQ-021 SHALL, in EMIT, hold coord_valid = 1 and keep coord and coord_metadata stable while coord_ready = 0.
REQ-022 SHALL, on each coordinate handshake (coord_valid && coord_ready), advance row-major: x+1 if x < max_x'; else x = min_x, y+1.
REQ-023 SHALL set coord_metadata.last = 1 iff x == max_x' and y == max_y'; 0 otherwise.
REQ-024 SHALL, on handshake of the last coordinate, return to IDLE with coord_valid = 0 the next cycle; bbox_ready rises that same next cycle (no same-cycle accept while in EMIT).
REQ-025 SHALL emit exactly (max_x'-min_x+1)*(max_y'-min_y+1) coordinates per non-empty box, with no gaps, duplicates or wrap beyond 10 bits.
REQ-026 SHALL ignore bbox_valid, bbox_min, bbox_max while in EMIT.
REQ-027 SHALL drive busy = 1 in EMIT, 0 in IDLE.
REQ-028 SHALL keep coord_valid = 0 in IDLE; coord value in IDLE is don't-care but SHALL not be X after reset.

Reset
REQ-029 SHALL, when reset = 1 at a rising edge, enter IDLE regardless of state, aborting any box in progress without emitting remaining coordinates.
REQ-030 SHALL drive after reset: bbox_ready = 1, coord_valid = 0, coord = {0,0}, coord_metadata.last = 0, busy = 0, empty_skip = 0.
REQ-031 SHALL let reset take priority over any simultaneous bbox or coord handshake; such handshakes have no effect.

Verification
REQ-032 SHALL cover: box min (2,3) max (4,4), coord_ready = 1 -> 6 coords (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), last only on (4,4), bbox_ready high the cycle after.
REQ-033 SHALL cover: box min (318,238) max (400,300) -> clamped, coords (318,238),(319,238),(318,239),(319,239), last on (319,239).
REQ-034 SHALL cover: box min (5,5) max (4,9) -> no coord_valid, empty_skip one-cycle pulse, bbox_ready stays 1.
REQ-035 SHALL cover: box min (0,0) max (1,0), coord_ready held 0 for 5 cycles then random toggling -> coord (0,0) stable while stalled; exactly (0,0),(1,0) delivered.
REQ-036 SHALL cover: box min (10,10) max (19,19), reset asserted after 3 handshakes -> coord_valid 0 and bbox_ready 1 the cycle after reset; next box (0,0)-(0,0) emits single coord with last = 1.
REQ-037 SHALL cover: single-pixel box min = max = (7,7) -> one coord (7,7) with last = 1 at latency 1.
